xgmii_tx_arb: RTL and testbench

//  Shares one 64-bit XGMII TX lane set (8 lanes, xgmii_t) between NUM_SRC pre-framed XGMII sources.

---
 rtl/xgmii_tx_arb_pkg.sv | 35 +++
 rtl/xgmii_tx_arb_if.sv | 16 +
 rtl/xgmii_tx_arb_rr_arb.sv | 31 +++
 rtl/xgmii_tx_arb.sv | 144 ++++++++++++++
 tb/tb_xgmii_tx_arb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/xgmii_tx_arb_pkg.sv
// Shared XGMII types, constants and helpers for the TX arbiter.
package xgmii_tx_arb_pkg;

  // One 64-bit XGMII transfer: 8 control bits (one per lane) over 8 data lanes.
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } xgmii_t;

  localparam logic [7:0] XGMII_CHAR_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_CHAR_START = 8'hfb;
  localparam logic [7:0] XGMII_CHAR_TERM  = 8'hfd;
  localparam logic [7:0] XGMII_CHAR_ERROR = 8'hfe;

  localparam xgmii_t XGMII_IDLE_WORD  = '{ctrl: 8'hff, data: {8{XGMII_CHAR_IDLE}}};
  localparam xgmii_t XGMII_ERROR_WORD = '{ctrl: 8'hff, data: {8{XGMII_CHAR_ERROR}}};

  typedef enum logic [1:0] {IDLE, PASS, IPG} tx_arb_state_t;

  // A frame opens with a START control character in lane 0.
  function automatic logic xgmii_is_start(xgmii_t w);
    return w.ctrl[0] && (w.data[7:0] == XGMII_CHAR_START);
  endfunction

  // A frame closes in whichever lane carries the TERMINATE control character.
  function automatic logic xgmii_has_term(xgmii_t w);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w.ctrl[i] && (w.data[8*i +: 8] == XGMII_CHAR_TERM)) t = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/xgmii_tx_arb_if.sv
// Source-side handshake plus the PCS-facing XGMII lane set.
interface xgmii_tx_arb_if
  import xgmii_tx_arb_pkg::*;
#(
  parameter int NUM_SRC = 2
);
  logic   [NUM_SRC-1:0] src_valid;
  xgmii_t [NUM_SRC-1:0] src_xgmii;
  logic   [NUM_SRC-1:0] src_ready;
  xgmii_t               xgmii_tx;

  // Frame generators and PCS side together.
  modport master (output src_valid, output src_xgmii, input src_ready, input xgmii_tx);
  // The arbiter.
  modport slave  (input src_valid, input src_xgmii, output src_ready, output xgmii_tx);
endinterface

// File: rtl/xgmii_tx_arb_rr_arb.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arb #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the pointer position; the first requester found wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_arb.sv
// Frame-granular round-robin arbiter sharing one XGMII TX lane set between sources.
module xgmii_tx_arb
  import xgmii_tx_arb_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int IPG_WORDS = 1,
  parameter int CNT_W     = 32,
  localparam int IDX_W    = $clog2(NUM_SRC)
) (
  input  logic             clk156,
  input  logic             sys_rst,
  xgmii_tx_arb_if.slave    bus,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic             underrun,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  tx_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [3:0]       ipg_cnt_q, ipg_cnt_d;
  xgmii_t           tx_q, tx_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               dropping;

  // Only sources offering a START word compete for the link.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = bus.src_valid[i] && xgmii_is_start(bus.src_xgmii[i]);
    end
  end

  rr_arb #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Next-state, handshake and output-word selection for the grant/pass/gap cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ipg_cnt_d   = ipg_cnt_q;
    tx_d        = XGMII_IDLE_WORD;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    ready       = '0;
    dropping    = 1'b0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (bus.src_valid[i] && !xgmii_is_start(bus.src_xgmii[i])) begin
            ready[i] = 1'b1;
            dropping = 1'b1;
          end
        end
        if (win_any) begin
          ready   = ready | win_gnt;
          grant_d = win_idx;
          ptr_d   = (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + IDX_W'(1);
          tx_d    = bus.src_xgmii[win_idx];
          if (xgmii_has_term(bus.src_xgmii[win_idx])) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            ipg_cnt_d   = 4'(IPG_WORDS);
            state_d     = (IPG_WORDS == 0) ? IDLE : IPG;
          end else begin
            state_d = PASS;
          end
        end
        if (dropping) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      PASS: begin
        ready[grant_q] = 1'b1;
        if (bus.src_valid[grant_q]) begin
          tx_d = bus.src_xgmii[grant_q];
          if (xgmii_has_term(bus.src_xgmii[grant_q])) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            ipg_cnt_d   = 4'(IPG_WORDS);
            state_d     = (IPG_WORDS == 0) ? IDLE : IPG;
          end
        end else begin
          tx_d       = XGMII_ERROR_WORD;
          underrun_d = 1'b1;
        end
      end
      IPG: begin
        if (ipg_cnt_q <= 4'd1) begin
          ipg_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          ipg_cnt_d = ipg_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, output word and counters all update together on the XGMII clock.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ipg_cnt_q   <= '0;
      tx_q        <= XGMII_IDLE_WORD;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ipg_cnt_q   <= ipg_cnt_d;
      tx_q        <= tx_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.src_ready = sys_rst ? '0 : ready;
  assign bus.xgmii_tx  = tx_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == PASS);
  assign underrun      = underrun_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_arb.sv
// Directed bench for xgmii_tx_arb with two sources and a one-word gap.
module tb_xgmii_tx_arb;
  import xgmii_tx_arb_pkg::*;

  localparam xgmii_t IDLE_W  = {8'hff, 64'h0707070707070707};
  localparam xgmii_t ERR_W   = {8'hff, 64'hfefefefefefefefe};
  localparam xgmii_t START0  = {8'h01, 64'hd5555555555555fb};
  localparam xgmii_t START1  = {8'h01, 64'hd5d5d5d5d5d5d5fb};
  localparam xgmii_t DATA0   = {8'h00, 64'h1122334455667788};
  localparam xgmii_t DATA1   = {8'h00, 64'h99aabbccddeeff00};
  localparam xgmii_t TERM0   = {8'hf0, 64'h070707fdaabbccdd};
  localparam xgmii_t TERM1   = {8'hff, 64'h07070707070707fd};
  localparam xgmii_t NONE    = {8'h00, 64'h0};

  logic        clk156 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        grant_id;
  logic        busy;
  logic        underrun;
  logic [31:0] frame_cnt;
  logic [31:0] drop_cnt;
  int          total = 0;
  int          bad = 0;

  xgmii_tx_arb_if #(.NUM_SRC(2)) bus ();

  xgmii_tx_arb #(.NUM_SRC(2), .IPG_WORDS(1), .CNT_W(32)) dut (
    .clk156    (clk156),
    .sys_rst   (sys_rst),
    .bus       (bus.slave),
    .grant_id  (grant_id),
    .busy      (busy),
    .underrun  (underrun),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk156 = ~clk156;

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic drive(input logic v0, input xgmii_t w0, input logic v1, input xgmii_t w1);
    bus.src_valid[0] = v0;
    bus.src_xgmii[0] = w0;
    bus.src_valid[1] = v1;
    bus.src_xgmii[1] = w1;
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    drive(1'b0, NONE, 1'b0, NONE);
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, NONE, 1'b0, NONE);
      total++; if (bus.src_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_ready c%0d: got %b want 00", c, bus.src_ready); end
      tick();
      total++; if (bus.xgmii_tx !== IDLE_W) begin bad++; $display("[TB] FAIL reset_tx c%0d: got %h want %h", c, bus.xgmii_tx, IDLE_W); end
      total++; if (frame_cnt !== 0 || drop_cnt !== 0) begin bad++; $display("[TB] FAIL reset_cnt c%0d: got %0d/%0d want 0/0", c, frame_cnt, drop_cnt); end
    end
    total++; if (busy !== 1'b0 || grant_id !== 1'b0 || underrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: got busy=%b gid=%b ur=%b want 0/0/0", busy, grant_id, underrun); end
  endtask

  task automatic test_single_frame();
    drive(1'b1, START0, 1'b0, NONE);
    total++; if (bus.src_ready !== 2'b01) begin bad++; $display("[TB] FAIL sf_ready: got %b want 01", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== START0) begin bad++; $display("[TB] FAIL sf_start: got %h want %h", bus.xgmii_tx, START0); end
    total++; if (busy !== 1'b1 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL sf_busy: got busy=%b gid=%b want 1/0", busy, grant_id); end
    drive(1'b1, DATA0, 1'b0, NONE);
    tick();
    total++; if (bus.xgmii_tx !== DATA0) begin bad++; $display("[TB] FAIL sf_data: got %h want %h", bus.xgmii_tx, DATA0); end
    drive(1'b1, TERM0, 1'b0, NONE);
    tick();
    total++; if (bus.xgmii_tx !== TERM0) begin bad++; $display("[TB] FAIL sf_term: got %h want %h", bus.xgmii_tx, TERM0); end
    total++; if (frame_cnt !== 32'd1) begin bad++; $display("[TB] FAIL sf_frame_cnt: got %0d want 1", frame_cnt); end
    drive(1'b0, NONE, 1'b0, NONE);
    tick();
    total++; if (bus.xgmii_tx !== IDLE_W || busy !== 1'b0) begin bad++; $display("[TB] FAIL sf_ipg: got %h busy=%b want %h busy=0", bus.xgmii_tx, busy, IDLE_W); end
    tick();
  endtask

  task automatic test_tie_break();
    do_reset();
    drive(1'b1, START0, 1'b1, START1);
    total++; if (bus.src_ready !== 2'b01) begin bad++; $display("[TB] FAIL tie1_ready: got %b want 01", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== START0 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL tie1_start: got %h gid=%b want %h gid=0", bus.xgmii_tx, grant_id, START0); end
    drive(1'b1, DATA0, 1'b1, START1);
    total++; if (bus.src_ready !== 2'b01) begin bad++; $display("[TB] FAIL tie1_pass_ready: got %b want 01", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== DATA0) begin bad++; $display("[TB] FAIL tie1_data: got %h want %h", bus.xgmii_tx, DATA0); end
    drive(1'b1, TERM0, 1'b1, START1);
    tick();
    total++; if (bus.xgmii_tx !== TERM0) begin bad++; $display("[TB] FAIL tie1_term: got %h want %h", bus.xgmii_tx, TERM0); end
    drive(1'b0, NONE, 1'b1, START1);
    total++; if (bus.src_ready !== 2'b00) begin bad++; $display("[TB] FAIL tie_ipg_ready: got %b want 00", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== IDLE_W) begin bad++; $display("[TB] FAIL tie_ipg_tx: got %h want %h", bus.xgmii_tx, IDLE_W); end
    total++; if (bus.src_ready !== 2'b10) begin bad++; $display("[TB] FAIL tie2_ready: got %b want 10", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== START1 || grant_id !== 1'b1) begin bad++; $display("[TB] FAIL tie2_start: got %h gid=%b want %h gid=1", bus.xgmii_tx, grant_id, START1); end
    drive(1'b1, START0, 1'b1, TERM1);
    tick();
    total++; if (bus.xgmii_tx !== TERM1 || frame_cnt !== 32'd2) begin bad++; $display("[TB] FAIL tie2_term: got %h cnt=%0d want %h cnt=2", bus.xgmii_tx, frame_cnt, TERM1); end
    drive(1'b1, START0, 1'b1, START1);
    total++; if (bus.src_ready !== 2'b00) begin bad++; $display("[TB] FAIL tie2_ipg_ready: got %b want 00", bus.src_ready); end
    tick();
    total++; if (bus.src_ready !== 2'b01) begin bad++; $display("[TB] FAIL tie3_ready: got %b want 01", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== START0 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL tie3_start: got %h gid=%b want %h gid=0", bus.xgmii_tx, grant_id, START0); end
    drive(1'b1, TERM0, 1'b0, NONE);
    tick();
    total++; if (bus.xgmii_tx !== TERM0 || frame_cnt !== 32'd3) begin bad++; $display("[TB] FAIL tie3_term: got %h cnt=%0d want %h cnt=3", bus.xgmii_tx, frame_cnt, TERM0); end
    drive(1'b0, NONE, 1'b0, NONE);
    tick();
    tick();
  endtask

  task automatic test_underrun();
    drive(1'b0, NONE, 1'b1, START1);
    total++; if (bus.src_ready !== 2'b10) begin bad++; $display("[TB] FAIL ur_ready: got %b want 10", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== START1 || grant_id !== 1'b1) begin bad++; $display("[TB] FAIL ur_start: got %h gid=%b want %h gid=1", bus.xgmii_tx, grant_id, START1); end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, NONE, 1'b0, NONE);
      tick();
      total++; if (bus.xgmii_tx !== ERR_W || underrun !== 1'b1) begin bad++; $display("[TB] FAIL ur_err c%0d: got %h ur=%b want %h ur=1", c, bus.xgmii_tx, underrun, ERR_W); end
    end
    drive(1'b0, NONE, 1'b1, DATA1);
    tick();
    total++; if (bus.xgmii_tx !== DATA1 || underrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL ur_resume: got %h ur=%b busy=%b want %h ur=0 busy=1", bus.xgmii_tx, underrun, busy, DATA1); end
    drive(1'b0, NONE, 1'b1, TERM1);
    tick();
    total++; if (bus.xgmii_tx !== TERM1 || frame_cnt !== 32'd4) begin bad++; $display("[TB] FAIL ur_term: got %h cnt=%0d want %h cnt=4", bus.xgmii_tx, frame_cnt, TERM1); end
    drive(1'b0, NONE, 1'b0, NONE);
    tick();
    tick();
  endtask

  task automatic test_drop();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, DATA0, 1'b0, NONE);
      total++; if (bus.src_ready !== 2'b01) begin bad++; $display("[TB] FAIL drop_ready c%0d: got %b want 01", c, bus.src_ready); end
      tick();
      total++; if (bus.xgmii_tx !== IDLE_W || drop_cnt !== 32'(c + 1)) begin bad++; $display("[TB] FAIL drop_tx c%0d: got %h cnt=%0d want %h cnt=%0d", c, bus.xgmii_tx, drop_cnt, IDLE_W, c + 1); end
    end
    drive(1'b1, DATA0, 1'b1, DATA1);
    total++; if (bus.src_ready !== 2'b11) begin bad++; $display("[TB] FAIL drop_both_ready: got %b want 11", bus.src_ready); end
    tick();
    total++; if (drop_cnt !== 32'd4) begin bad++; $display("[TB] FAIL drop_both_cnt: got %0d want 4", drop_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, START0, 1'b0, NONE);
    tick();
    total++; if (bus.xgmii_tx !== START0 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL rst_pre_start: got %h gid=%b want %h gid=0", bus.xgmii_tx, grant_id, START0); end
    drive(1'b1, DATA0, 1'b0, NONE);
    tick();
    sys_rst = 1'b1;
    drive(1'b1, DATA0, 1'b1, START1);
    tick();
    total++; if (bus.xgmii_tx !== IDLE_W || busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_tx: got %h busy=%b want %h busy=0", bus.xgmii_tx, busy, IDLE_W); end
    total++; if (frame_cnt !== 0 || drop_cnt !== 0 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_cnt: got %0d/%0d gid=%b want 0/0 gid=0", frame_cnt, drop_cnt, grant_id); end
    total++; if (bus.src_ready !== 2'b00) begin bad++; $display("[TB] FAIL rst_mid_ready: got %b want 00", bus.src_ready); end
    sys_rst = 1'b0;
    drive(1'b1, START0, 1'b1, START1);
    total++; if (bus.src_ready !== 2'b01) begin bad++; $display("[TB] FAIL rst_new_ready: got %b want 01", bus.src_ready); end
    tick();
    total++; if (bus.xgmii_tx !== START0 || grant_id !== 1'b0) begin bad++; $display("[TB] FAIL rst_new_start: got %h gid=%b want %h gid=0", bus.xgmii_tx, grant_id, START0); end
    drive(1'b1, TERM0, 1'b1, START1);
    tick();
    total++; if (bus.xgmii_tx !== TERM0 || frame_cnt !== 32'd1) begin bad++; $display("[TB] FAIL rst_new_term: got %h cnt=%0d want %h cnt=1", bus.xgmii_tx, frame_cnt, TERM0); end
    drive(1'b0, NONE, 1'b0, NONE);
    tick();
  endtask

  initial begin
    bus.src_valid = '0;
    bus.src_xgmii = '0;
    test_reset();
    test_single_frame();
    test_tie_break();
    test_underrun();
    test_drop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
